// File: rtl/triumph_pkg.sv
// Shared RV32I decode constants, micro-op encoding and immediate helpers.
// Pure definitions, no timing.
// No handshakes here; consumers own all flow control.
package triumph_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int OP_W_DEF = 5;

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // funct3 codes
  localparam logic [2:0] F3_ADD_SUB = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4, F3_SRL_SRA = 3'd5, F3_OR = 3'd6, F3_AND = 3'd7;
  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_LB = 3'd0, F3_LH = 3'd1, F3_LW = 3'd2, F3_LBU = 3'd4, F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB = 3'd0, F3_SH = 3'd1, F3_SW = 3'd2;

  // Micro-ops. Register and immediate ALU forms share a code: R-type carries
  // imm=0 and I-type carries rs2 data=0, so EX can use (rs2 | imm) as operand B.
  localparam logic [OP_W_DEF-1:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLL = 5'd2, OP_SLT = 5'd3;
  localparam logic [OP_W_DEF-1:0] OP_SLTU = 5'd4, OP_XOR = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7;
  localparam logic [OP_W_DEF-1:0] OP_OR = 5'd8, OP_AND = 5'd9, OP_LUI = 5'd10, OP_AUIPC = 5'd11;
  localparam logic [OP_W_DEF-1:0] OP_JAL = 5'd12, OP_JALR = 5'd13;
  localparam logic [OP_W_DEF-1:0] OP_BEQ = 5'd14, OP_BNE = 5'd15, OP_BLT = 5'd16, OP_BGE = 5'd17;
  localparam logic [OP_W_DEF-1:0] OP_BLTU = 5'd18, OP_BGEU = 5'd19;
  localparam logic [OP_W_DEF-1:0] OP_LB = 5'd20, OP_LH = 5'd21, OP_LW = 5'd22, OP_LBU = 5'd23;
  localparam logic [OP_W_DEF-1:0] OP_LHU = 5'd24, OP_SB = 5'd25, OP_SH = 5'd26, OP_SW = 5'd27;
  localparam logic [OP_W_DEF-1:0] OP_FENCE = 5'd28, OP_SYSTEM = 5'd29, OP_ILLEGAL = 5'd31;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  // ALU micro-op from funct3; alt selects SUB/SRA
  function automatic logic [OP_W_DEF-1:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [OP_W_DEF-1:0] op;
    case (f3)
      F3_ADD_SUB: op = alt ? OP_SUB : OP_ADD;
      F3_SLL:     op = OP_SLL;
      F3_SLT:     op = OP_SLT;
      F3_SLTU:    op = OP_SLTU;
      F3_XOR:     op = OP_XOR;
      F3_SRL_SRA: op = alt ? OP_SRA : OP_SRL;
      F3_OR:      op = OP_OR;
      default:    op = OP_AND;
    endcase
    return op;
  endfunction

  // Sign-extended immediate in byte units
  function automatic logic [31:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] ir);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
      IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_U:   imm = {ir[31:12], 12'b0};
      IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/triumph_regfile.sv
// Architectural register file: 2 async read ports, 1 sync write port, x0 hardwired.
// Reads are combinational; writes land at the clock edge.
// A read of the address being written returns the write data (write-through).
module triumph_regfile
  import triumph_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [4:0]      ra1_i,
  input  logic [4:0]      ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  // Next register contents; x0 never takes a write
  always_comb begin
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    if (we_i && wa_i != '0) regs_d[wa_i] = wd_i;
    regs_d[0] = '0;
  end

  // Register array state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports with write-through bypass
  always_comb begin
    rd1_o = regs_q[ra1_i];
    rd2_o = regs_q[ra2_i];
    if (we_i && wa_i == ra1_i) rd1_o = wd_i;
    if (we_i && wa_i == ra2_i) rd2_o = wd_i;
    if (ra1_i == '0) rd1_o = '0;
    if (ra2_i == '0) rd2_o = '0;
  end

endmodule

// File: rtl/triumph_id_stage.sv
// RV32I decode stage: decode, regfile read, RAW interlock, ID/EX register.
// Latency 1: word accepted in cycle N is on ex_* in N+1.
// Stalls (id_ready_o=0) on hazard, on a full ID/EX entry EX won't take, or on flush.
module triumph_id_stage
  import triumph_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int OP_W = OP_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_valid_i,
  input  logic [31:0]     instr_data_i,
  output logic            id_ready_o,
  input  logic            flush_i,
  output logic [31:0]     opPC_data_o,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [OP_W-1:0] ex_op_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rd_addr_o,
  output logic            ex_rd_we_o,
  output logic            ex_illegal_o,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_waddr_i,
  input  logic [XLEN-1:0] wb_wdata_i
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  imm_fmt_e   dec_fmt;
  logic [OP_W-1:0] dec_op;
  logic       dec_use1, dec_use2, dec_wr, dec_ill;
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic       hazard, fire_in, fire_out;

  logic            ex_valid_q, ex_valid_d;
  logic [OP_W-1:0] ex_op_q, ex_op_d;
  logic [XLEN-1:0] ex_rs1_data_q, ex_rs1_data_d;
  logic [XLEN-1:0] ex_rs2_data_q, ex_rs2_data_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;
  logic [4:0]      ex_rd_addr_q, ex_rd_addr_d;
  logic            ex_rd_we_q, ex_rd_we_d;
  logic            ex_illegal_q, ex_illegal_d;
  logic [NREG-1:0] sb_q, sb_d;

  assign opc = instr_data_i[6:0];
  assign f3  = instr_data_i[14:12];
  assign rs1 = instr_data_i[19:15];
  assign rs2 = instr_data_i[24:20];
  assign rd  = instr_data_i[11:7];

  triumph_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ra1_i (rs1),
    .ra2_i (rs2),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2),
    .we_i  (wb_we_i),
    .wa_i  (wb_waddr_i),
    .wd_i  (wb_wdata_i)
  );

  // Decode: micro-op, immediate format, operand usage, legality
  always_comb begin
    dec_op   = OP_ILLEGAL;
    dec_fmt  = IMM_NONE;
    dec_use1 = 1'b0;
    dec_use2 = 1'b0;
    dec_wr   = 1'b0;
    dec_ill  = 1'b0;
    case (opc)
      OPC_LUI:   begin dec_op = OP_LUI;   dec_fmt = IMM_U; dec_wr = 1'b1; end
      OPC_AUIPC: begin dec_op = OP_AUIPC; dec_fmt = IMM_U; dec_wr = 1'b1; end
      OPC_JAL:   begin dec_op = OP_JAL;   dec_fmt = IMM_J; dec_wr = 1'b1; end
      OPC_JALR: begin
        dec_op = OP_JALR; dec_fmt = IMM_I; dec_wr = 1'b1; dec_use1 = 1'b1;
        dec_ill = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        dec_fmt = IMM_B; dec_use1 = 1'b1; dec_use2 = 1'b1;
        case (f3)
          F3_BEQ:  dec_op = OP_BEQ;
          F3_BNE:  dec_op = OP_BNE;
          F3_BLT:  dec_op = OP_BLT;
          F3_BGE:  dec_op = OP_BGE;
          F3_BLTU: dec_op = OP_BLTU;
          F3_BGEU: dec_op = OP_BGEU;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_fmt = IMM_I; dec_use1 = 1'b1; dec_wr = 1'b1;
        case (f3)
          F3_LB:   dec_op = OP_LB;
          F3_LH:   dec_op = OP_LH;
          F3_LW:   dec_op = OP_LW;
          F3_LBU:  dec_op = OP_LBU;
          F3_LHU:  dec_op = OP_LHU;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec_fmt = IMM_S; dec_use1 = 1'b1; dec_use2 = 1'b1;
        case (f3)
          F3_SB:   dec_op = OP_SB;
          F3_SH:   dec_op = OP_SH;
          F3_SW:   dec_op = OP_SW;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec_fmt = IMM_I; dec_use1 = 1'b1; dec_wr = 1'b1;
        dec_op = alu_op(f3, (f3 == F3_SRL_SRA) && instr_data_i[30]);
      end
      OPC_OP: begin
        dec_use1 = 1'b1; dec_use2 = 1'b1; dec_wr = 1'b1;
        dec_op = alu_op(f3, instr_data_i[30]);
        dec_ill = (instr_data_i[31:25] != 7'h00) &&
                  !((instr_data_i[31:25] == 7'h20) && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA));
      end
      OPC_FENCE:  dec_op = OP_FENCE;
      OPC_SYSTEM: dec_op = OP_SYSTEM;
      default:    dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_op   = OP_ILLEGAL;
      dec_fmt  = IMM_NONE;
      dec_use1 = 1'b0;
      dec_use2 = 1'b0;
      dec_wr   = 1'b0;
    end
  end

  // RAW interlock: pending scoreboard writer (unless retiring now) or producer sitting in ID/EX
  always_comb begin
    hazard = 1'b0;
    if (dec_use1 && rs1 != '0)
      hazard = hazard | (sb_q[rs1] && !(wb_we_i && wb_waddr_i == rs1))
                      | (ex_valid_q && ex_rd_we_q && ex_rd_addr_q == rs1);
    if (dec_use2 && rs2 != '0)
      hazard = hazard | (sb_q[rs2] && !(wb_we_i && wb_waddr_i == rs2))
                      | (ex_valid_q && ex_rd_we_q && ex_rd_addr_q == rs2);
  end

  assign id_ready_o = !hazard && (!ex_valid_q || ex_ready_i) && !flush_i;
  assign fire_in    = instr_valid_i && id_ready_o;
  assign fire_out   = ex_valid_q && ex_ready_i;

  // ID/EX next state and scoreboard update (set after clear so a new producer wins)
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_op_d       = ex_op_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rd_addr_d  = ex_rd_addr_q;
    ex_rd_we_d    = ex_rd_we_q;
    ex_illegal_d  = ex_illegal_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (fire_in) begin
      ex_valid_d    = 1'b1;
      ex_op_d       = dec_op;
      ex_rs1_data_d = dec_use1 ? rf_rd1 : '0;
      ex_rs2_data_d = dec_use2 ? rf_rd2 : '0;
      ex_imm_d      = gen_imm(dec_fmt, instr_data_i);
      ex_rd_addr_d  = dec_wr ? rd : 5'd0;
      ex_rd_we_d    = dec_wr && (rd != '0);
      ex_illegal_d  = dec_ill;
    end else if (fire_out) begin
      ex_valid_d = 1'b0;
    end
    sb_d = sb_q;
    if (wb_we_i) sb_d[wb_waddr_i] = 1'b0;
    if (fire_out && ex_rd_we_q && !flush_i) sb_d[ex_rd_addr_q] = 1'b1;
  end

  // Pipeline and scoreboard registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_q    <= 1'b0;
      ex_op_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rd_addr_q  <= '0;
      ex_rd_we_q    <= 1'b0;
      ex_illegal_q  <= 1'b0;
      sb_q          <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_op_q       <= ex_op_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rd_addr_q  <= ex_rd_addr_d;
      ex_rd_we_q    <= ex_rd_we_d;
      ex_illegal_q  <= ex_illegal_d;
      sb_q          <= sb_d;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_op_o       = ex_op_q;
  assign ex_rs1_data_o = ex_rs1_data_q;
  assign ex_rs2_data_o = ex_rs2_data_q;
  assign ex_imm_o      = ex_imm_q;
  assign ex_rd_addr_o  = ex_rd_addr_q;
  assign ex_rd_we_o    = ex_rd_we_q;
  assign ex_illegal_o  = ex_illegal_q;

  // Word-scaled PC offset for PC-relative control transfers only
  assign opPC_data_o = (ex_valid_q && ((ex_op_q >= OP_BEQ && ex_op_q <= OP_BGEU) || ex_op_q == OP_JAL))
                       ? {ex_imm_q[31], ex_imm_q[31], ex_imm_q[31:2]} : 32'd0;

endmodule
